gaussian5x5_stream_sequencer: RTL and testbench
===============================================

// Module: gaussian5x5_stream_sequencer
// PURPOSE
//  Frame-level controller for the separable 5x5 Gaussian datapath (line buffer plus row/column pipeline).
//  Accepts a valid/ready pixel stream and drives the datapath clock-enable (dp_en).
//  Primes the line buffer, then emits one output per advance with SOP/EOP and a border-mask flag.
//  At end of frame, flushes the pipeline with zero pixels so every one of IMG_W*IMG_H centres is produced.
// PARAMETERS
//  IMG_W     640  pixels per row (>=5)
//  IMG_H     480  rows per frame (>=5)
//  PIPE_LAT  2    datapath register stages after the line-buffer taps (>=0)
//  DELAY     2*IMG_W+2+PIPE_LAT (localparam) advances from input centre to its output
// PORTS
//  clk           in   1   clock; all flops on posedge
//  rst_n         in   1   async active-low reset
//  in_valid      in   1   input pixel present
//  in_ready      out  1   sequencer accepts input this cycle
//  in_sop        in   1   first pixel of frame
//  in_eop        in   1   last pixel of frame (checked only)
//  dp_en         out  1   datapath/line-buffer clock enable (one advance)
//  dp_flush_sel  out  1   1: datapath input muxed to 8'd0 (flush)
//  out_valid     out  1   datapath o_pixel holds a valid output
//  out_ready     in   1   downstream accepts output
//  out_sop       out  1   held output is centre (0,0)
//  out_eop       out  1   held output is centre (IMG_W-1,IMG_H-1)
//  out_border    out  1   held output lies within 2 px of any edge; datapath forces it to 0
//  busy          out  1   state != IDLE
//  frame_done    out  1   1-cycle pulse on FLUSH->IDLE
//  err_sync      out  1   1-cycle pulse on framing error
// BEHAVIOUR
//  Reset (async): state=IDLE; all counters 0; out_valid/sop/eop/border, frame_done, err_sync = 0.
//   in_ready=0 and dp_en=0 while rst_n=0. Mid-frame reset aborts the frame; no partial output follows.
//  FSM IDLE -> FILL -> RUN -> FLUSH -> IDLE.
//   IDLE:  in_ready = ~out_valid. in_valid&in_ready&in_sop: dp_en=1, in_cnt=1, go FILL.
//          Accepted pixel without SOP is dropped (dp_en=0) and pulses err_sync.
//   FILL:  in_ready=1; dp_en = in_valid. No outputs produced.
//          Go RUN on the advance where in_cnt reaches DELAY.
//   RUN:   in_ready = ~out_valid | out_ready; dp_en = in_valid & in_ready. Each advance produces one output.
//          Advance that accepts pixel IMG_W*IMG_H-1 goes FLUSH.
//   FLUSH: in_ready=0; dp_flush_sel=1; dp_en = ~out_valid | out_ready. Each advance produces one output.
//          Advance DELAY goes IDLE and pulses frame_done.
//  Output register: on a producing advance, out_valid<=1 and sop/eop/border<=f(out_x,out_y); out_x/out_y step.
//   Otherwise, out_ready clears out_valid.
//   Output data and flags stay stable while out_valid & ~out_ready, because dp_en=0 then.
//  Counters: in_cnt, flush_cnt are $clog2(IMG_W*IMG_H+1) bits. out_x wraps at IMG_W-1 and increments out_y.
//   out_y wraps at IMG_H-1.
//  Border = out_x<2 | out_x>IMG_W-3 | out_y<2 | out_y>IMG_H-3.
//  Framing checks (FILL/RUN): accepted in_sop on in_cnt!=0 pulses err_sync, pixel treated as normal.
//   in_eop != (in_cnt==IMG_W*IMG_H-1) pulses err_sync. Input count is authoritative, never resynced.
//  Totals per frame: exactly IMG_W*IMG_H accepted inputs, IMG_W*IMG_H outputs, DELAY flush advances.
//  Next frame's SOP is not accepted before IDLE with out_valid=0, so the held output is never corrupted.
// TESTING (IMG_W=9, IMG_H=6, PIPE_LAT=2 -> DELAY=22, 54 px)
//  1 54 px back-to-back, out_ready=1 -> in_ready always 1; first out_valid the cycle after 23rd accept.
//    54 outputs, sop on #1, eop on #54, 44 border/10 interior, one frame_done.
//  2 out_ready=0 for 5 cycles in RUN -> in_ready=0, dp_en=0, out_valid/flags held; resumes with no loss.
//  3 3 px without SOP in IDLE -> 3 err_sync pulses, dp_en=0; following SOP frame gives 54 correct outputs.
//  4 in_eop on pixel 30 -> one err_sync pulse; frame still completes 54 outputs and frame_done.
//  5 rst_n low 1 cycle at pixel 40 -> IDLE, out_valid=0 immediately; next frame yields 54 outputs.
//  6 2nd SOP presented during FLUSH with out_ready toggling -> held (in_ready=0) until IDLE & out_valid=0.

Source files
------------

// File: rtl/gaussian5x5_stream_sequencer.sv
// Frame-level sequencer for the separable 5x5 Gaussian datapath: primes the line buffer,
// paces one output per datapath advance, and flushes with zero pixels at end of frame.
module gaussian5x5_stream_sequencer #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int PIPE_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_sop,
  input  logic in_eop,
  output logic dp_en,
  output logic dp_flush_sel,
  output logic out_valid,
  input  logic out_ready,
  output logic out_sop,
  output logic out_eop,
  output logic out_border,
  output logic busy,
  output logic frame_done,
  output logic err_sync
);

  localparam int NPX   = IMG_W * IMG_H;
  localparam int DELAY = 2 * IMG_W + 2 + PIPE_LAT;
  localparam int CW    = $clog2(NPX + 1);
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);

  localparam logic [CW-1:0] LAST_PX    = CW'(NPX - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY - 1);
  localparam logic [XW-1:0] X_LAST     = XW'(IMG_W - 1);
  localparam logic [XW-1:0] X_HI       = XW'(IMG_W - 3);
  localparam logic [XW-1:0] X_LO       = XW'(2);
  localparam logic [YW-1:0] Y_LAST     = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_HI       = YW'(IMG_H - 3);
  localparam logic [YW-1:0] Y_LO       = YW'(2);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] in_cnt, flush_cnt;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          start, accept, produce, err_nxt, done_nxt;

  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    dp_en        = 1'b0;
    dp_flush_sel = 1'b0;
    start        = 1'b0;
    accept       = 1'b0;
    produce      = 1'b0;
    err_nxt      = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~out_valid;
        if (in_valid && in_ready) begin
          if (in_sop) begin
            dp_en     = 1'b1;
            start     = 1'b1;
            state_nxt = FILL;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      FILL: begin
        in_ready = 1'b1;
        dp_en    = in_valid;
        accept   = in_valid;
        if (accept) begin
          err_nxt = in_sop | (in_eop != (in_cnt == LAST_PX));
          if (in_cnt == DELAY_LAST) state_nxt = RUN;
        end
      end
      RUN: begin
        in_ready = ~out_valid | out_ready;
        dp_en    = in_valid & in_ready;
        accept   = dp_en;
        produce  = dp_en;
        if (accept) begin
          err_nxt = in_sop | (in_eop != (in_cnt == LAST_PX));
          if (in_cnt == LAST_PX) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        dp_flush_sel = 1'b1;
        dp_en        = ~out_valid | out_ready;
        produce      = dp_en;
        if (dp_en && flush_cnt == DELAY_LAST) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Handshake outputs are forced quiet while reset is held, not just after it.
    in_ready = in_ready & rst_n;
    dp_en    = dp_en & rst_n;
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_cnt     <= '0;
      flush_cnt  <= '0;
      out_x      <= '0;
      out_y      <= '0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_border <= 1'b0;
      frame_done <= 1'b0;
      err_sync   <= 1'b0;
    end else begin
      state      <= state_nxt;
      err_sync   <= err_nxt;
      frame_done <= done_nxt;
      if (start) begin
        in_cnt    <= CW'(1);
        flush_cnt <= '0;
        out_x     <= '0;
        out_y     <= '0;
      end else if (accept) begin
        in_cnt <= in_cnt + 1'b1;
      end
      if (state == FLUSH && dp_en) flush_cnt <= flush_cnt + 1'b1;
      if (done_nxt) begin
        in_cnt    <= '0;
        flush_cnt <= '0;
      end
      // Flags describe the centre being emitted; the coordinate then steps to the next one.
      if (produce) begin
        out_valid  <= 1'b1;
        out_sop    <= (out_x == '0) && (out_y == '0);
        out_eop    <= (out_x == X_LAST) && (out_y == Y_LAST);
        out_border <= (out_x < X_LO) || (out_x > X_HI) || (out_y < Y_LO) || (out_y > Y_HI);
        if (out_x == X_LAST) begin
          out_x <= '0;
          out_y <= (out_y == Y_LAST) ? '0 : out_y + 1'b1;
        end else begin
          out_x <= out_x + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gaussian5x5_stream_sequencer.sv
// Self-checking bench for the Gaussian stream sequencer on a 9x6 frame.
module tb_gaussian5x5_stream_sequencer;

  localparam int unsigned W     = 9;
  localparam int unsigned H     = 6;
  localparam int unsigned PL    = 2;
  localparam int unsigned NPX   = W * H;
  localparam int unsigned DELAY = 2 * W + 2 + PL;
  localparam int unsigned TMO   = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, dp_en, dp_flush_sel, out_valid, out_sop, out_eop, out_border;
  logic busy, frame_done, err_sync;

  int tests = 0;
  int fails = 0;
  int rdy_mode = 0;

  // Monitor state (written only by the monitor process)
  int unsigned mon_acc = 0, fd_cnt = 0, err_cnt = 0, dpen_cnt = 0;
  logic [2:0] cap_q[$];
  int unsigned rise_q[$];
  bit prev_ov = 0;

  gaussian5x5_stream_sequencer #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
    .dp_en(dp_en), .dp_flush_sel(dp_flush_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_border(out_border),
    .busy(busy), .frame_done(frame_done), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(1));

  always @(negedge clk) begin
    #4;
    if (rst_n) begin
      if (out_valid && !prev_ov) rise_q.push_back(mon_acc);
      prev_ov = out_valid;
      if (out_valid && out_ready) cap_q.push_back({out_sop, out_eop, out_border});
      if (in_valid && in_ready) mon_acc++;
      if (frame_done) fd_cnt++;
      if (err_sync) err_cnt++;
      if (dp_en) dpen_cnt++;
    end else begin
      prev_ov = 1'b0;
    end
  end

  // Reference: output k of a frame is centre (k%W, k/W) in raster order.
  function automatic logic [2:0] exp_flags(input int unsigned k);
    int unsigned x = k % W;
    int unsigned y = k / W;
    exp_flags = {k == 0, k == NPX - 1, (x < 2) || (x > W - 3) || (y < 2) || (y > H - 3)};
  endfunction

  task automatic set_mode(input int m);
    #1 rdy_mode = m;
    @(negedge clk);
  endtask

  task automatic push_px(input logic sop, input logic eop, output int unsigned waited,
                         output logic acc_busy, output logic acc_ov);
    bit got = 0;
    waited = 0; acc_busy = 0; acc_ov = 0;
    in_valid = 1'b1; in_sop = sop; in_eop = eop;
    while (!got && waited < TMO) begin
      #2;
      if (in_ready) begin
        got = 1; acc_busy = busy; acc_ov = out_valid;
      end else begin
        waited++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send_frame(input int unsigned npx, input int unsigned bubble, input int unsigned eop_at,
                            output int unsigned stalls, output int unsigned tmo,
                            output int unsigned fw, output logic fb, output logic fo);
    int unsigned w;
    logic b, o;
    stalls = 0; tmo = 0; fw = 0; fb = 0; fo = 0;
    for (int unsigned i = 0; i < npx; i++) begin
      push_px(i == 0, (i == NPX - 1) || (i + 1 == eop_at), w, b, o);
      if (i == 0) begin fw = w; fb = b; fo = o; end
      stalls += w;
      if (w >= TMO) tmo++;
      if (bubble != 0 && $urandom_range(99) < bubble) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int unsigned target, output bit tmo);
    int unsigned n = 0;
    while (fd_cnt < target && n < 1000) begin @(negedge clk); n++; end
    tmo = (fd_cnt < target);
    set_mode(0);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({out_valid, out_sop, out_eop, out_border, in_ready, dp_en, busy, frame_done, err_sync} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %b required 000000000",
               {out_valid, out_sop, out_eop, out_border, in_ready, dp_en, busy, frame_done, err_sync});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      fails++;
      $display("FAIL post_reset_idle: in_ready/busy/out_valid=%b required 100", {in_ready, busy, out_valid});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int unsigned b_cap = cap_q.size(), b_rise = rise_q.size(), b_acc = mon_acc;
    int unsigned b_fd = fd_cnt, b_err = err_cnt, b_dp = dpen_cnt;
    int unsigned st, tmo, fw, lat, bad, nb;
    logic fb, fo;
    bit dto;
    set_mode(0);
    send_frame(NPX, 0, 0, st, tmo, fw, fb, fo);
    wait_done(b_fd + 1, dto);
    tests++;
    if (st !== 0 || tmo !== 0) begin fails++; $display("FAIL b2b_in_ready: stall cycles %0d required 0", st); end
    lat = (rise_q.size() > b_rise) ? rise_q[b_rise] - b_acc : 0;
    tests++;
    if (lat !== 23) begin fails++; $display("FAIL b2b_first_out: accepts before first out_valid %0d required 23", lat); end
    tests++;
    if (cap_q.size() - b_cap !== NPX) begin fails++; $display("FAIL b2b_out_count: got %0d required %0d", cap_q.size() - b_cap, NPX); end
    bad = 0; nb = 0;
    for (int unsigned k = 0; k < NPX; k++)
      if (cap_q.size() > b_cap + k) begin
        if (cap_q[b_cap + k] !== exp_flags(k)) bad++;
        if (cap_q[b_cap + k][0]) nb++;
      end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL b2b_flags: %0d outputs with wrong sop/eop/border, required 0", bad); end
    tests++;
    if (nb !== 44) begin fails++; $display("FAIL b2b_border_count: got %0d required 44", nb); end
    tests++;
    if (fd_cnt - b_fd !== 1 || dto) begin fails++; $display("FAIL b2b_frame_done: pulses %0d required 1", fd_cnt - b_fd); end
    tests++;
    if (dpen_cnt - b_dp !== NPX + DELAY) begin fails++; $display("FAIL b2b_dp_en_count: got %0d required %0d", dpen_cnt - b_dp, NPX + DELAY); end
    tests++;
    if (err_cnt - b_err !== 0) begin fails++; $display("FAIL b2b_err_sync: pulses %0d required 0", err_cnt - b_err); end
  endtask

  task automatic test_backpressure();
    int unsigned b_cap = cap_q.size(), b_acc = mon_acc, b_fd = fd_cnt, b_err = err_cnt;
    int unsigned st, tmo, fw, bad, hs_bad, hold_bad, n;
    logic fb, fo;
    bit dto;
    hs_bad = 0; hold_bad = 0; n = 0;
    fork
      send_frame(NPX, 0, 0, st, tmo, fw, fb, fo);
      begin
        while (mon_acc < b_acc + 30 && n < TMO) begin @(negedge clk); n++; end
        #1 rdy_mode = 1;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          #3;
          if (in_ready !== 1'b0 || dp_en !== 1'b0) hs_bad++;
          if (out_valid !== 1'b1 || {out_sop, out_eop, out_border} !== exp_flags(cap_q.size() - b_cap)) hold_bad++;
        end
        rdy_mode = 0;
      end
    join
    wait_done(b_fd + 1, dto);
    tests++;
    if (hs_bad !== 0) begin fails++; $display("FAIL stall_handshake: %0d cycles with in_ready/dp_en high, required 0", hs_bad); end
    tests++;
    if (hold_bad !== 0) begin fails++; $display("FAIL stall_hold: %0d cycles with output not held, required 0", hold_bad); end
    bad = 0;
    for (int unsigned k = 0; k < NPX; k++)
      if (cap_q.size() > b_cap + k && cap_q[b_cap + k] !== exp_flags(k)) bad++;
    tests++;
    if (cap_q.size() - b_cap !== NPX || bad !== 0) begin
      fails++;
      $display("FAIL stall_outputs: count %0d bad %0d required %0d bad 0", cap_q.size() - b_cap, bad, NPX);
    end
    tests++;
    if (fd_cnt - b_fd !== 1 || err_cnt - b_err !== 0 || dto) begin
      fails++;
      $display("FAIL stall_done_err: frame_done %0d err %0d required 1 0", fd_cnt - b_fd, err_cnt - b_err);
    end
  endtask

  task automatic test_no_sop();
    int unsigned b_err = err_cnt, b_dp = dpen_cnt, b_fd, b_cap;
    int unsigned w, st, tmo, fw, bad;
    logic b, o, fb, fo;
    bit dto;
    for (int i = 0; i < 3; i++) push_px(1'b0, 1'b0, w, b, o);
    repeat (2) @(negedge clk);
    tests++;
    if (err_cnt - b_err !== 3) begin fails++; $display("FAIL nosop_err: pulses %0d required 3", err_cnt - b_err); end
    tests++;
    if (dpen_cnt - b_dp !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL nosop_dropped: dp_en %0d busy %b required 0 0", dpen_cnt - b_dp, busy);
    end
    b_fd = fd_cnt; b_cap = cap_q.size();
    send_frame(NPX, 30, 0, st, tmo, fw, fb, fo);
    wait_done(b_fd + 1, dto);
    bad = 0;
    for (int unsigned k = 0; k < NPX; k++)
      if (cap_q.size() > b_cap + k && cap_q[b_cap + k] !== exp_flags(k)) bad++;
    tests++;
    if (cap_q.size() - b_cap !== NPX || bad !== 0 || dto) begin
      fails++;
      $display("FAIL nosop_next_frame: count %0d bad %0d required %0d bad 0", cap_q.size() - b_cap, bad, NPX);
    end
  endtask

  task automatic test_eop_error();
    int unsigned b_err = err_cnt, b_fd = fd_cnt, b_cap = cap_q.size();
    int unsigned st, tmo, fw, bad;
    logic fb, fo;
    bit dto;
    send_frame(NPX, 0, 30, st, tmo, fw, fb, fo);
    wait_done(b_fd + 1, dto);
    tests++;
    if (err_cnt - b_err !== 1) begin fails++; $display("FAIL eop_err_pulse: pulses %0d required 1", err_cnt - b_err); end
    bad = 0;
    for (int unsigned k = 0; k < NPX; k++)
      if (cap_q.size() > b_cap + k && cap_q[b_cap + k] !== exp_flags(k)) bad++;
    tests++;
    if (cap_q.size() - b_cap !== NPX || bad !== 0 || fd_cnt - b_fd !== 1) begin
      fails++;
      $display("FAIL eop_err_frame: count %0d bad %0d done %0d required %0d 0 1", cap_q.size() - b_cap, bad, fd_cnt - b_fd, NPX);
    end
  endtask

  task automatic test_mid_reset();
    int unsigned b_cap, b_fd;
    int unsigned st, tmo, fw, bad;
    logic fb, fo;
    bit dto;
    send_frame(40, 0, 0, st, tmo, fw, fb, fo);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, busy, in_ready, dp_en} !== 4'b0000) begin
      fails++;
      $display("FAIL midreset_outputs: out_valid/busy/in_ready/dp_en=%b required 0000", {out_valid, busy, in_ready, dp_en});
    end
    @(negedge clk);
    rst_n = 1'b1;
    b_cap = cap_q.size(); b_fd = fd_cnt;
    repeat (30) @(negedge clk);
    tests++;
    if (cap_q.size() - b_cap !== 0 || fd_cnt - b_fd !== 0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL midreset_no_partial: outputs %0d done %0d required 0 0", cap_q.size() - b_cap, fd_cnt - b_fd);
    end
    send_frame(NPX, 0, 0, st, tmo, fw, fb, fo);
    wait_done(b_fd + 1, dto);
    bad = 0;
    for (int unsigned k = 0; k < NPX; k++)
      if (cap_q.size() > b_cap + k && cap_q[b_cap + k] !== exp_flags(k)) bad++;
    tests++;
    if (cap_q.size() - b_cap !== NPX || bad !== 0 || dto) begin
      fails++;
      $display("FAIL midreset_next_frame: count %0d bad %0d required %0d bad 0", cap_q.size() - b_cap, bad, NPX);
    end
  endtask

  task automatic test_sop_during_flush();
    int unsigned b_cap = cap_q.size(), b_fd = fd_cnt, b_err = err_cnt;
    int unsigned st, tmo, fw, fw2, bad;
    logic fb, fo, fb2, fo2;
    bit dto;
    set_mode(2);
    send_frame(NPX, 20, 0, st, tmo, fw, fb, fo);
    send_frame(NPX, 20, 0, st, tmo, fw2, fb2, fo2);
    wait_done(b_fd + 2, dto);
    tests++;
    if (fw2 < DELAY || tmo !== 0) begin fails++; $display("FAIL flush_sop_wait: waited %0d cycles required >= %0d", fw2, DELAY); end
    tests++;
    if ({fb2, fo2} !== 2'b00) begin fails++; $display("FAIL flush_sop_accept_state: busy/out_valid=%b required 00", {fb2, fo2}); end
    bad = 0;
    for (int unsigned k = 0; k < 2 * NPX; k++)
      if (cap_q.size() > b_cap + k && cap_q[b_cap + k] !== exp_flags(k % NPX)) bad++;
    tests++;
    if (cap_q.size() - b_cap !== 2 * NPX || bad !== 0) begin
      fails++;
      $display("FAIL flush_two_frames: count %0d bad %0d required %0d bad 0", cap_q.size() - b_cap, bad, 2 * NPX);
    end
    tests++;
    if (fd_cnt - b_fd !== 2 || err_cnt - b_err !== 0 || dto) begin
      fails++;
      $display("FAIL flush_done_err: frame_done %0d err %0d required 2 0", fd_cnt - b_fd, err_cnt - b_err);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_no_sop();
    test_eop_error();
    test_mid_reset();
    test_sop_during_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
